// File: rtl/lfsr_rng_arbiter.sv
// Two-requester round-robin front end for one 5-bit maximal-length LFSR.
// Each grant pulse hands out the current value, then the register steps.
module lfsr_rng_arbiter #(
  parameter logic [4:0] RESET_SEED = 5'b00001
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] req,
  input  logic       seed_load,
  input  logic [4:0] seed_val,
  output logic [1:0] gnt,
  output logic       rnd_valid,
  output logic [4:0] rnd_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    SERVE,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [4:0] seed_q, seed_d;
  logic       last_q, last_d;
  logic       win_q, win_d;
  logic       win_c;

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    win_c = ~last_q;
    unique case (1'b1)
      (req == 2'b01): win_c = 1'b0;
      (req == 2'b10): win_c = 1'b1;
      default:        win_c = ~last_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    last_d    = last_q;
    win_d     = win_q;
    gnt       = 2'b00;
    rnd_valid = 1'b0;
    rnd_data  = 5'b00000;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          state_d = SEED;
          seed_d  = seed_val;
        end else if (|req) begin
          state_d = SERVE;
          win_d   = win_c;
        end
      end
      SEED: begin
        state_d = IDLE;
        lfsr_d  = (seed_q == 5'b00000) ? RESET_SEED : seed_q;
      end
      SERVE: begin
        gnt       = win_q ? 2'b10 : 2'b01;
        rnd_valid = 1'b1;
        rnd_data  = lfsr_q;
        busy      = 1'b1;
        lfsr_d    = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
        last_d    = win_q;
        state_d   = GAP;
      end
      GAP: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state, so an async reset clears them at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= RESET_SEED;
      seed_q  <= RESET_SEED;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: cycle model plus directed and random stimulus.
// Model tracks cooldown cycles and pending winner, not the FSM encoding.
module tb_lfsr_rng_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       seed_load = 1'b0;
  logic [4:0] seed_val = 5'b00000;
  logic [1:0] gnt;
  logic       rnd_valid;
  logic [4:0] rnd_data;
  logic       busy;

  lfsr_rng_arbiter #(.RESET_SEED(5'b00001)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .gnt      (gnt),
    .rnd_valid(rnd_valid),
    .rnd_data (rnd_data),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  int         m_cool;
  int         m_who;
  bit         m_seeding;
  logic [4:0] m_lfsr;
  int         m_last;

  logic [4:0] dq[$];
  logic [1:0] gq[$];
  int         cq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] step(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [4:0] dget(input int i);
    if (i < dq.size()) return dq[i];
    return 5'bxxxxx;
  endfunction

  function automatic logic [1:0] gget(input int i);
    if (i < gq.size()) return gq[i];
    return 2'bxx;
  endfunction

  always @(posedge sys_clk) cyc++;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_cool    = 0;
      m_who     = -1;
      m_seeding = 1'b0;
      m_lfsr    = 5'b00001;
      m_last    = 1;
    end else if (m_cool > 0) begin
      if (m_who >= 0) begin
        m_lfsr = step(m_lfsr);
        m_last = m_who;
        m_who  = -1;
      end
      m_seeding = 1'b0;
      m_cool--;
    end else if (seed_load) begin
      m_lfsr    = (seed_val == 5'b00000) ? 5'b00001 : seed_val;
      m_seeding = 1'b1;
      m_cool    = 1;
    end else if (req != 2'b00) begin
      if (req == 2'b11) m_who = 1 - m_last;
      else m_who = (req == 2'b01) ? 0 : 1;
      m_cool = 2;
    end
  end

  always @(negedge sys_clk) begin
    logic [1:0] eg;
    logic [4:0] ed;
    if (chk_on) begin
      eg = (m_who < 0) ? 2'b00 : ((m_who == 0) ? 2'b01 : 2'b10);
      ed = (m_who < 0) ? 5'b00000 : m_lfsr;
      chk("gnt", gnt, eg);
      chk("rnd_valid", rnd_valid, m_who >= 0);
      chk("rnd_data", rnd_data, ed);
      chk("busy", busy, (m_cool > 0) && !m_seeding);
      if (m_who >= 0) begin
        dq.push_back(ed);
        gq.push_back(eg);
        cq.push_back(cyc);
      end
    end
  end

  task automatic wait_del(input int n, input int budget);
    int k = 0;
    while (dq.size() < n && k < budget) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    total++;
    if (dq.size() < n) begin
      bad++;
      $display("FAIL wait_del got=%0d want=%0d", dq.size(), n);
    end
  endtask

  task automatic clr();
    dq.delete();
    gq.delete();
    cq.delete();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    req = 2'b00;
    seed_load = 1'b0;
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clr();
  endtask

  task automatic idle(input int n);
    req = 2'b00;
    seed_load = 1'b0;
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  initial begin
    int t0;
    int uniq;
    int zeros;
    bit seen[32];

    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_data", rnd_data, 5'b00000);
    chk("rst_busy", busy, 1'b0);
    chk_on = 1'b1;
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Single requester, three deliveries and pulse spacing
    clr();
    t0 = cyc;
    req = 2'b01;
    wait_del(3, 20);
    req = 2'b00;
    chk("t1_d0", dget(0), 5'b00001);
    chk("t1_d1", dget(1), 5'b00010);
    chk("t1_d2", dget(2), 5'b00100);
    chk("t1_g2", gget(2), 2'b01);
    chk("t1_lat", (cq.size() > 0) ? cq[0] : -1, t0 + 1);
    chk("t1_gap", (cq.size() > 1) ? cq[1] - cq[0] : -1, 3);
    idle(3);

    // Both requesting: alternate grants on one global sequence
    do_reset();
    req = 2'b11;
    wait_del(6, 30);
    req = 2'b00;
    chk("t2_g0", gget(0), 2'b01);
    chk("t2_g1", gget(1), 2'b10);
    chk("t2_g4", gget(4), 2'b01);
    chk("t2_g5", gget(5), 2'b10);
    chk("t2_d3", dget(3), 5'b01001);
    chk("t2_d4", dget(4), 5'b10010);
    chk("t2_d5", dget(5), 5'b00101);
    idle(3);

    // Seed load, then zero-seed substitution
    do_reset();
    seed_val = 5'b10010;
    seed_load = 1'b1;
    @(negedge sys_clk);
    #1;
    seed_load = 1'b0;
    req = 2'b10;
    wait_del(2, 20);
    req = 2'b00;
    chk("t3_g0", gget(0), 2'b10);
    chk("t3_d0", dget(0), 5'b10010);
    chk("t3_d1", dget(1), 5'b00101);
    idle(3);
    clr();
    seed_val = 5'b00000;
    seed_load = 1'b1;
    @(negedge sys_clk);
    #1;
    seed_load = 1'b0;
    req = 2'b01;
    wait_del(1, 20);
    req = 2'b00;
    chk("t3_zero", dget(0), 5'b00001);
    idle(3);

    // Full period
    do_reset();
    req = 2'b01;
    wait_del(32, 150);
    req = 2'b00;
    uniq = 0;
    zeros = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 31 && i < dq.size(); i++) begin
      if (dq[i] == 5'b00000) zeros++;
      if (!seen[dq[i]]) uniq++;
      seen[dq[i]] = 1'b1;
    end
    chk("t4_distinct", uniq, 31);
    chk("t4_nonzero", zeros, 0);
    chk("t4_wrap", dget(31), 5'b00001);
    idle(3);

    // Seed beats req; seed_load in GAP ignored
    do_reset();
    seed_val = 5'b01000;
    seed_load = 1'b1;
    req = 2'b01;
    @(negedge sys_clk);
    #1;
    seed_load = 1'b0;
    chk("t5_nognt", gnt, 2'b00);
    wait_del(1, 20);
    req = 2'b00;
    chk("t5_d0", dget(0), 5'b01000);
    @(negedge sys_clk);
    #1;
    seed_val = 5'b00011;
    seed_load = 1'b1;
    @(negedge sys_clk);
    #1;
    seed_load = 1'b0;
    req = 2'b01;
    wait_del(2, 20);
    req = 2'b00;
    chk("t5_gapseed", dget(1), 5'b10000);
    idle(3);

    // Async reset mid-SERVE
    do_reset();
    req = 2'b01;
    wait_del(1, 20);
    chk("t6_pre", rnd_valid, 1'b1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_gnt", gnt, 2'b00);
    chk("t6_valid", rnd_valid, 1'b0);
    chk("t6_data", rnd_data, 5'b00000);
    chk("t6_busy", busy, 1'b0);
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clr();
    wait_del(1, 20);
    req = 2'b00;
    chk("t6_after", dget(0), 5'b00001);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req = 2'($urandom_range(0, 3));
      seed_load = ($urandom_range(0, 9) == 0);
      seed_val = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 3));
        sys_rst_n = 1'b0;
        #1;
        sys_rst_n = 1'b1;
      end
      @(negedge sys_clk);
      #1;
    end
    idle(3);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Shares one 5-bit maximal-length LFSR random-number source between two requesters.
- Uses round-robin arbitration and a pulse-style grant/data handshake.
- Provides a seed-load port for reproducible sequences.
- Sits between the LFSR datapath and consumer blocks (e.g. test-pattern generators, randomised counters) that each need their own stream of 5-bit values.

Parameters:
- RESET_SEED, 5'b00001, LFSR value after reset; also the substitute for an all-zero seed load.

Ports:
- sys_clk, input, 1, system clock; all state changes on the rising edge.
- sys_rst_n, input, 1, asynchronous active-low reset.
- req, input, 2, per-requester request; held high until its gnt bit pulses.
- seed_load, input, 1, load seed_val into the LFSR (sampled only in IDLE).
- seed_val, input, 5, seed value.
- gnt, output, 2, one-hot grant; pulses for exactly one cycle in SERVE.
- rnd_valid, output, 1, high exactly when gnt is non-zero.
- rnd_data, output, 5, delivered random value; valid only when rnd_valid=1, else 5'b00000.
- busy, output, 1, high in SERVE and GAP.

Behaviour:
- Reset values: gnt=2'b00, rnd_valid=0, rnd_data=5'b00000, busy=0, LFSR=RESET_SEED, FSM=IDLE, last-grant pointer=1 (so requester 0 wins the first tie).
  - Reset is asynchronous and takes effect immediately in any state, including mid-SERVE.
  - No partial grant survives a reset.
- LFSR: Fibonacci, polynomial x^5+x^3+1.
  - Q_next = {Q[3:0], Q[4]^Q[2]}.
  - Period 31; never reaches 5'b00000.
  - Advances only on a delivery (the SERVE cycle), never while idle.
- FSM states: IDLE, SEED, SERVE, GAP.
  - IDLE:
    - seed_load=1 -> SEED. seed_load has priority over req.
    - Otherwise req!=0 -> SERVE, with the grant winner latched.
    - Otherwise stay in IDLE.
  - SEED, 1 cycle:
    - LFSR <= (seed_val==0) ? RESET_SEED : seed_val.
    - Outputs stay low; busy=0. Next state IDLE.
  - SERVE, 1 cycle:
    - gnt = one-hot of winner; rnd_valid=1; rnd_data = current LFSR value.
    - LFSR <= Q_next; last pointer <= winner. Next state GAP.
  - GAP, 1 cycle:
    - All outputs low, busy=1. Lets the served requester drop req. Next state IDLE.
- Arbitration, resolved on the IDLE->SERVE edge:
  - Only one bit of req set -> that requester wins.
  - Both bits set -> the requester that is not the last-granted one wins.
- Latency: req sampled high in IDLE at edge k -> gnt/rnd_valid high in cycle k+1 -> GAP in k+2 -> IDLE in k+3. Throughput is one delivery per 3 cycles.
- req changes during SERVE or GAP are ignored. A req still high when the FSM returns to IDLE is a new request.
- seed_load during SERVE or GAP is ignored (not queued).
- The delivered value sequence is global: two requesters interleaving see alternate elements of the same sequence.

Test Plan:
1. Reset, then hold req=2'b01 for 3 deliveries -> gnt=01 each time; rnd_data=00001, 00010, 00100; a pulse every 3 cycles; first pulse 1 cycle after req is sampled in IDLE.
2. Reset, then hold req=2'b11 continuously -> gnt sequence 01,10,01,10,01,10; rnd_data 00001, 00010, 00100, 01001, 10010, 00101.
3. seed_load=1 with seed_val=10010 in IDLE, then req=2'b10 -> gnt=10, rnd_data=10010; next delivery 00101. Repeat with seed_val=00000 -> first delivered value 00001.
4. 31 consecutive deliveries from reset -> all 31 values distinct, none equal to 00000; delivery 32 returns 00001.
5. Assert seed_load and req=01 in the same IDLE cycle with seed_val=01000 -> SEED first (no gnt that cycle), then SERVE delivers 01000. Assert seed_load during GAP -> ignored, LFSR unchanged.
6. Drive sys_rst_n low during SERVE -> gnt, rnd_valid, rnd_data and busy clear immediately without waiting for a clock. After release with req=01 held, the next delivery is 00001.
